// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: owns the PC, drives the instruction memory
// address and loads the returned word into the IF/ID register, with stall/freeze/redirect handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        freeze,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q,             pc_d;
    logic [31:0] ifid_instr_q,     ifid_instr_d;
    logic [31:0] ifid_pc_q,        ifid_pc_d;
    logic [31:0] ifid_pc_plus4_q,  ifid_pc_plus4_d;
    logic        ifid_valid_q,     ifid_valid_d;
    logic        misalign_err_q,   misalign_err_d;
    logic [31:0] fetch_count_q,    fetch_count_d;
    logic        pending_valid_q,  pending_valid_d;
    logic [31:0] pending_target_q, pending_target_d;

    logic        eff_valid;
    logic [31:0] eff_target;
    logic [31:0] aligned_target;
    logic [31:0] pc_plus4;

    // A live redirect from EX always beats one parked during a freeze.
    assign eff_valid      = redirect_valid | pending_valid_q;
    assign eff_target     = redirect_valid ? redirect_target : pending_target_q;
    assign aligned_target = {eff_target[31:2], 2'b00};
    assign pc_plus4       = pc_q + 32'd4;

    always_comb begin
        pc_d             = pc_q;
        ifid_instr_d     = ifid_instr_q;
        ifid_pc_d        = ifid_pc_q;
        ifid_pc_plus4_d  = ifid_pc_plus4_q;
        ifid_valid_d     = ifid_valid_q;
        misalign_err_d   = misalign_err_q;
        fetch_count_d    = fetch_count_q;
        pending_valid_d  = pending_valid_q;
        pending_target_d = pending_target_q;

        if (freeze) begin
            if (redirect_valid) begin
                pending_valid_d  = 1'b1;
                pending_target_d = redirect_target;
                if (redirect_target[1:0] != 2'b00) begin
                    misalign_err_d = 1'b1;
                end
            end
        end else if (eff_valid) begin
            // Redirect wins over stall: the instruction held in ID is wrong-path.
            pc_d            = aligned_target;
            ifid_instr_d    = NOP_INSTR;
            ifid_valid_d    = 1'b0;
            pending_valid_d = 1'b0;
            if (eff_target[1:0] != 2'b00) begin
                misalign_err_d = 1'b1;
            end
        end else if (!stall) begin
            pc_d            = pc_plus4;
            ifid_instr_d    = imem_rdata;
            ifid_pc_d       = pc_q;
            ifid_pc_plus4_d = pc_plus4;
            ifid_valid_d    = 1'b1;
            fetch_count_d   = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q             <= RESET_PC;
            ifid_instr_q     <= NOP_INSTR;
            ifid_pc_q        <= 32'd0;
            ifid_pc_plus4_q  <= 32'd0;
            ifid_valid_q     <= 1'b0;
            misalign_err_q   <= 1'b0;
            fetch_count_q    <= 32'd0;
            pending_valid_q  <= 1'b0;
            pending_target_q <= 32'd0;
        end else begin
            pc_q             <= pc_d;
            ifid_instr_q     <= ifid_instr_d;
            ifid_pc_q        <= ifid_pc_d;
            ifid_pc_plus4_q  <= ifid_pc_plus4_d;
            ifid_valid_q     <= ifid_valid_d;
            misalign_err_q   <= misalign_err_d;
            fetch_count_q    <= fetch_count_d;
            pending_valid_q  <= pending_valid_d;
            pending_target_q <= pending_target_d;
        end
    end

    assign imem_addr     = pc_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;
    assign ifid_valid    = ifid_valid_q;
    assign misalign_err  = misalign_err_q;
    assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a behavioural fetch model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        freeze;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .freeze          (freeze),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .ifid_valid      (ifid_valid),
        .misalign_err    (misalign_err),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: address-dependent pattern, with the test-plan word at 0.
    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        if (a == 32'd0) return 32'h00A2_8433;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    assign imem_rdata = imem_fn(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural state of the fetch stage.
    logic [31:0] m_pc, m_instr, m_ipc, m_ip4, m_cnt, m_pt;
    logic        m_vld, m_mis, m_pv;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] t;
        if (!rst_n) begin
            m_pc = 32'd0; m_instr = NOP; m_ipc = 32'd0; m_ip4 = 32'd0;
            m_vld = 1'b0; m_mis = 1'b0; m_cnt = 32'd0; m_pv = 1'b0; m_pt = 32'd0;
        end else if (freeze) begin
            if (redirect_valid) begin
                m_pv = 1'b1;
                m_pt = redirect_target;
                if (redirect_target % 4 != 0) m_mis = 1'b1;
            end
        end else if (redirect_valid || m_pv) begin
            t = redirect_valid ? redirect_target : m_pt;
            if (t % 4 != 0) m_mis = 1'b1;
            m_pc    = t - (t % 4);
            m_instr = NOP;
            m_vld   = 1'b0;
            m_pv    = 1'b0;
        end else if (!stall) begin
            m_instr = imem_fn(m_pc);
            m_ipc   = m_pc;
            m_ip4   = m_pc + 4;
            m_vld   = 1'b1;
            m_pc    = m_pc + 4;
            m_cnt   = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_imem_addr", imem_addr, m_pc);
            check("model_ifid_instr", ifid_instr, m_instr);
            check("model_ifid_pc", ifid_pc, m_ipc);
            check("model_ifid_pc_plus4", ifid_pc_plus4, m_ip4);
            check("model_ifid_valid", {31'd0, ifid_valid}, {31'd0, m_vld});
            check("model_misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
            check("model_fetch_count", fetch_count, m_cnt);
        end
    end

    task automatic drive(input bit s, input bit f, input bit rv, input logic [31:0] rt);
        stall = s; freeze = f; redirect_valid = rv; redirect_target = rt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 32'd0);
        repeat (2) @(negedge clk);
        check("reset_imem_addr", imem_addr, 32'd0);
        check("reset_ifid_instr", ifid_instr, NOP);
        check("reset_ifid_pc", ifid_pc, 32'd0);
        check("reset_ifid_valid", {31'd0, ifid_valid}, 32'd0);
        check("reset_fetch_count", fetch_count, 32'd0);
        check("reset_misalign", {31'd0, misalign_err}, 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // First fetch
        @(negedge clk);
        check("first_instr", ifid_instr, 32'h00A2_8433);
        check("first_pc", ifid_pc, 32'd0);
        check("first_pc4", ifid_pc_plus4, 32'd4);
        check("first_valid", {31'd0, ifid_valid}, 32'd1);
        check("first_addr", imem_addr, 32'd4);
        check("first_count", fetch_count, 32'd1);

        // Stall for three cycles with PC=8
        @(negedge clk);
        check("pre_stall_addr", imem_addr, 32'd8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_addr", imem_addr, 32'd8);
            check("stall_ifid_pc", ifid_pc, 32'd4);
        end
        stall = 1'b0;
        @(negedge clk);
        check("post_stall_ifid_pc", ifid_pc, 32'd8);
        check("post_stall_instr", ifid_instr, imem_fn(32'd8));
        check("post_stall_addr", imem_addr, 32'd12);
        check("post_stall_count", fetch_count, 32'd3);

        // Redirect overriding stall
        drive(1, 0, 1, 32'h40);
        @(negedge clk);
        check("redir_addr", imem_addr, 32'h40);
        check("redir_valid", {31'd0, ifid_valid}, 32'd0);
        check("redir_instr", ifid_instr, NOP);
        check("redir_count", fetch_count, 32'd3);
        drive(0, 0, 0, 32'd0);
        @(negedge clk);
        check("after_redir_pc", ifid_pc, 32'h40);
        check("after_redir_addr", imem_addr, 32'h44);

        // Freeze with two redirects; latest wins
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, (i == 1) || (i == 3), (i == 1) ? 32'h20 : 32'h3C);
            @(negedge clk);
            check("freeze_addr", imem_addr, 32'h44);
            check("freeze_ifid_pc", ifid_pc, 32'h40);
            check("freeze_count", fetch_count, 32'd4);
        end
        drive(0, 0, 0, 32'd0);
        @(negedge clk);
        check("unfreeze_addr", imem_addr, 32'h3C);
        check("unfreeze_valid", {31'd0, ifid_valid}, 32'd0);

        // Misaligned redirect is sticky
        drive(0, 0, 1, 32'h42);
        @(negedge clk);
        check("misalign_addr", imem_addr, 32'h40);
        check("misalign_set", {31'd0, misalign_err}, 32'd1);
        drive(0, 0, 1, 32'h100);
        @(negedge clk);
        check("misalign_sticky", {31'd0, misalign_err}, 32'd1);
        check("aligned_addr", imem_addr, 32'h100);

        // Top-of-space wrap, then asynchronous reset mid-cycle
        drive(0, 0, 1, 32'hFFFF_FFFC);
        @(negedge clk);
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 32'd0);
        @(negedge clk);
        check("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", ifid_pc_plus4, 32'd0);
        check("wrap_addr", imem_addr, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_addr", imem_addr, 32'd0);
        check("async_valid", {31'd0, ifid_valid}, 32'd0);
        check("async_instr", ifid_instr, NOP);
        check("async_ifid_pc", ifid_pc, 32'd0);
        check("async_count", fetch_count, 32'd0);
        check("async_misalign", {31'd0, misalign_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset discards a pending redirect captured during freeze
        drive(0, 1, 1, 32'h80);
        @(negedge clk);
        drive(0, 1, 0, 32'd0);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        drive(0, 0, 0, 32'd0);
        @(negedge clk);
        check("pending_discard_addr", imem_addr, 32'd4);
        check("pending_discard_valid", {31'd0, ifid_valid}, 32'd1);

        // Randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | {28'd0, tgt[3:0]};
            else if ($urandom_range(0, 1) == 0) tgt = {tgt[31:2], 2'b00};
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 6) == 0, tgt);
            if ($urandom_range(0, 99) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
